// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for logic_unit_arbiter: two requester channels and one
// shared response channel tagged with the issuing requester's ID.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/NOT/XOR) between two requesters.
// Define LOGIC_UNIT_ARBITER_XOR_EN to build the XOR datapath; otherwise op 11 reports an error.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic [1:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_id;
    logic [WIDTH-1:0] unit_result;
    logic             unit_err;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant && !rst;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant && !rst;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign bus.rsp_valid  = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        unit_result = '0;
        unit_err    = 1'b0;
        case (cap_op)
            2'b00: unit_result = cap_a & cap_b;
            2'b01: unit_result = cap_a | cap_b;
            2'b10: unit_result = ~cap_a;
`ifdef LOGIC_UNIT_ARBITER_XOR_EN
            2'b11: unit_result = cap_a ^ cap_b;
`else
            2'b11: begin
                unit_result = '0;
                unit_err    = 1'b1;
            end
`endif
            default: unit_result = '0;
        endcase
    end

    // Reset also clears the response registers so an in-flight result is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cap_op       <= 2'b00;
            cap_a        <= '0;
            cap_b        <= '0;
            cap_id       <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_op     <= grant ? bus.req1_op : bus.req0_op;
                cap_a      <= grant ? bus.req1_a  : bus.req0_a;
                cap_b      <= grant ? bus.req1_b  : bus.req0_b;
                cap_id     <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                bus.rsp_data <= unit_result;
                bus.rsp_id   <= cap_id;
                bus.rsp_err  <= unit_err;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios followed by randomized
// traffic, each compared against a behavioural round-robin/logic-unit model.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_last;

    logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {err, data} from the opcode rules alone.
    function automatic logic [WIDTH:0] model_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'b00: return {1'b0, a & b};
            2'b01: return {1'b0, a | b};
            2'b10: return {1'b0, ~a};
`ifdef LOGIC_UNIT_ARBITER_XOR_EN
            default: return {1'b0, a ^ b};
`else
            default: return {1'b1, {WIDTH{1'b0}}};
`endif
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [1:0] op0,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic v1, input logic [1:0] op1,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("ready0_in_reset", {31'd0, bus.req0_ready}, 32'd0);
        checkOutput("ready1_in_reset", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_last = 1;
    endtask

    // One full transaction from the accept cycle through the response hand-off.
    task automatic issue(input string tag, input int hold,
                         input logic v0, input logic [1:0] op0,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                         input logic v1, input logic [1:0] op1,
                         input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
        int win;
        logic [WIDTH:0] exp_rsp;
        applyStimulus(v0, op0, a0, b0, v1, op1, a1, b1);
        if (v0 && v1) win = (exp_last == 1) ? 0 : 1;
        else          win = v0 ? 0 : 1;
        exp_rsp = (win == 0) ? model_op(op0, a0, b0) : model_op(op1, a1, b1);

        @(negedge clk);
        checkOutput({tag, "_ready0"}, {31'd0, bus.req0_ready}, (win == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_ready1"}, {31'd0, bus.req1_ready}, (win == 1) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        exp_last = win;

        bus.req0_a = WIDTH'($urandom);
        bus.req0_b = WIDTH'($urandom);
        bus.req1_a = WIDTH'($urandom);
        bus.req1_b = WIDTH'($urandom);
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        checkOutput({tag, "_exec_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput({tag, "_exec_readys"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        @(posedge clk); #1;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            checkOutput({tag, "_hold_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_rsp[WIDTH-1:0]});
            checkOutput({tag, "_hold_id"}, {31'd0, bus.rsp_id}, 32'(win));
            checkOutput({tag, "_hold_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_rsp[WIDTH]});
            checkOutput({tag, "_hold_readys"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            @(posedge clk); #1;
        end

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        checkOutput({tag, "_rsp_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_rsp[WIDTH-1:0]});
        checkOutput({tag, "_rsp_id"}, {31'd0, bus.rsp_id}, 32'(win));
        checkOutput({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_rsp[WIDTH]});
        checkOutput({tag, "_rsp_readys"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_last = 1;
        rst      = 1'b1;
        bus.rsp_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0);
        @(posedge clk); #1;

        doReset();
        @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        checkOutput("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk); #1;

        issue("and0", 0, 1'b1, 2'b00, 8'b10101010, 8'b10101010, 1'b0, 2'b00, 8'h00, 8'h00);

        doReset();
        for (int i = 0; i < 4; i++) begin
            issue("alternate", 0, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b1, 2'b01, 8'hAA, 8'h55);
        end

        issue("not1", 0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 8'h0F, 8'hAA);
        issue("op11", 0, 1'b1, 2'b11, 8'hAA, 8'h55, 1'b0, 2'b00, 8'h00, 8'h00);
        issue("hold5", 5, 1'b1, 2'b01, 8'h3C, 8'hC0, 1'b1, 2'b00, 8'h12, 8'h34);

        // Reset arriving while the operation is in EXEC.
        applyStimulus(1'b1, 2'b01, 8'hF0, 8'h0F, 1'b0, 2'b00, 8'h00, 8'h00);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_last = 1;
        @(negedge clk);
        checkOutput("rst_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("rst_exec_data", {24'd0, bus.rsp_data}, 32'd0);
        @(posedge clk); #1;
        issue("post_rst", 0, 1'b1, 2'b10, 8'h5A, 8'h00, 1'b1, 2'b00, 8'hFF, 8'h0F);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            issue("random", int'($urandom_range(0, 2)),
                  sel[0], 2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                  sel[1], 2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
